sw_mailbox_ctrl: RTL and testbench

Sequences the two octal command/response latches that connect the main CPU and the sound CPU in the Star Wars core. Generates the latch-enable strobes from single-cycle bus write/read pulses, tracks full/empty state and overruns per direction, raises the sound CPU NMI on pending commands, and runs the main-CPU-initiated sound-CPU reset sequence. Sits between the two CPU address decoders and the audio subsystem, in the system clock domain.

---
 rtl/sw_mailbox_pkg.sv | 21 ++
 rtl/sw_mailbox_chan.sv | 78 +++++++
 rtl/sw_mailbox_ctrl.sv | 125 ++++++++++++
 tb/tb_sw_mailbox_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sw_mailbox_pkg.sv
// sw_mailbox_pkg
//   Shared types for the main/sound CPU mailbox controller:
//   channel state, reset-sequencer state and the sequencer counter width helper.
package sw_mailbox_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_HOLD = 1'b1
    } seq_state_e;

    // Bits needed to hold RST_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sw_mailbox_chan.sv
// sw_mailbox_chan
//   One mailbox direction: WIDTH-bit latch, EMPTY/FULL state and sticky overrun.
//   Ports:
//     clk, rst_n      system clock / async active-low reset
//     wr, din         write strobe and data (latch loads on the strobe edge)
//     rd              consume strobe
//     flush           force EMPTY and clear overrun (latch contents kept)
//     clr_ovr         clear the overrun flag
//     dout, full, ovr latch contents, pending flag, sticky overrun
//
//   state    | meaning
//   CH_EMPTY | nothing pending for the reader
//   CH_FULL  | latch holds an unread value
module sw_mailbox_chan
    import sw_mailbox_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    input  logic             flush,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             ovr
);

    ch_state_e        state_q, state_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_EMPTY;
            ovr_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
            if (wr) begin
                data_q <= din;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        if (flush) begin
            // A write landing on the flush edge is still accepted.
            state_d = wr ? CH_FULL : CH_EMPTY;
            ovr_d   = 1'b0;
        end else if (wr) begin
            state_d = CH_FULL;
            // A read in the same cycle consumes the old value, so no overrun.
            if (state_q == CH_FULL && !rd) begin
                ovr_d = 1'b1;
            end else if (clr_ovr) begin
                ovr_d = 1'b0;
            end
        end else begin
            if (rd) begin
                state_d = CH_EMPTY;
            end
            if (clr_ovr) begin
                ovr_d = 1'b0;
            end
        end
    end

    assign dout = data_q;
    assign full = (state_q == CH_FULL);
    assign ovr  = ovr_q;

endmodule

// File: rtl/sw_mailbox_ctrl.sv
// sw_mailbox_ctrl
//   Command/response mailbox between the main CPU and the sound CPU, plus the
//   main-CPU-initiated sound CPU reset sequencer.
//   Ports:
//     Clk, Reset_bar            system clock / async active-low reset
//     main_wr, main_din         command write strobe/data (main side)
//     main_rd, main_dout        response consume strobe / response latch
//     snd_wr, snd_din           response write strobe/data (sound side)
//     snd_rd, snd_dout          command consume strobe / command latch
//     cmd_full, rsp_full        pending flags per direction
//     cmd_ovr, rsp_ovr          sticky overrun flags
//     clr_ovr                   clear both overrun flags
//     snd_nmi                   NMI level to sound CPU (pending command)
//     snd_rst_req               request a sound CPU reset
//     snd_reset_bar             active-low reset to sound CPU
//
//   state    | meaning
//   SEQ_RUN  | sound CPU running, sound-side strobes honoured
//   SEQ_HOLD | sound CPU held in reset, counter running down to 0
module sw_mailbox_ctrl
    import sw_mailbox_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RST_CYCLES = 32
) (
    input  logic             Clk,
    input  logic             Reset_bar,
    input  logic             main_wr,
    input  logic [WIDTH-1:0] main_din,
    input  logic             main_rd,
    output logic [WIDTH-1:0] main_dout,
    input  logic             snd_wr,
    input  logic [WIDTH-1:0] snd_din,
    input  logic             snd_rd,
    output logic [WIDTH-1:0] snd_dout,
    output logic             cmd_full,
    output logic             rsp_full,
    output logic             cmd_ovr,
    output logic             rsp_ovr,
    output logic             snd_nmi,
    input  logic             snd_rst_req,
    output logic             snd_reset_bar,
    input  logic             clr_ovr
);

    localparam int              CNT_W    = cnt_width(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

    seq_state_e       seq_q, seq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush;
    logic             snd_ok;

    always_ff @(posedge Clk or negedge Reset_bar) begin
        if (!Reset_bar) begin
            seq_q <= SEQ_HOLD;
            cnt_q <= CNT_LOAD;
        end else begin
            seq_q <= seq_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        seq_d = seq_q;
        cnt_d = cnt_q;
        unique case (seq_q)
            SEQ_RUN: begin
                if (snd_rst_req) begin
                    seq_d = SEQ_HOLD;
                    cnt_d = CNT_LOAD;
                end
            end
            SEQ_HOLD: begin
                if (snd_rst_req) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    seq_d = SEQ_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                seq_d = SEQ_HOLD;
                cnt_d = CNT_LOAD;
            end
        endcase
    end

    // Channels are flushed only on the RUN->HOLD transition; a re-request
    // while already holding just restarts the counter.
    assign flush  = (seq_q == SEQ_RUN) && snd_rst_req;
    // The sound CPU is (or is about to be) in reset: drop its strobes.
    assign snd_ok = (seq_q == SEQ_RUN) && !snd_rst_req;

    sw_mailbox_chan #(.WIDTH(WIDTH)) u_cmd (
        .clk     (Clk),
        .rst_n   (Reset_bar),
        .wr      (main_wr),
        .din     (main_din),
        .rd      (snd_rd && snd_ok),
        .flush   (flush),
        .clr_ovr (clr_ovr),
        .dout    (snd_dout),
        .full    (cmd_full),
        .ovr     (cmd_ovr)
    );

    sw_mailbox_chan #(.WIDTH(WIDTH)) u_rsp (
        .clk     (Clk),
        .rst_n   (Reset_bar),
        .wr      (snd_wr && snd_ok),
        .din     (snd_din),
        .rd      (main_rd),
        .flush   (flush),
        .clr_ovr (clr_ovr),
        .dout    (main_dout),
        .full    (rsp_full),
        .ovr     (rsp_ovr)
    );

    assign snd_nmi       = cmd_full;
    assign snd_reset_bar = (seq_q == SEQ_RUN);

endmodule

// File: tb/tb_sw_mailbox_ctrl.sv
// tb_sw_mailbox_ctrl
//   Directed scenarios followed by random strobes, compared against a
//   behavioural model of both mailbox directions and the sound-reset timer.
module tb_sw_mailbox_ctrl;

    localparam int WIDTH      = 8;
    localparam int RST_CYCLES = 32;

    logic             Clk = 1'b0;
    logic             Reset_bar;
    logic             main_wr, main_rd, snd_wr, snd_rd, snd_rst_req, clr_ovr;
    logic [WIDTH-1:0] main_din, snd_din;
    logic [WIDTH-1:0] main_dout, snd_dout;
    logic             cmd_full, rsp_full, cmd_ovr, rsp_ovr, snd_nmi, snd_reset_bar;

    int errs   = 0;
    int checks = 0;

    // model state
    logic             m_cmd_full, m_rsp_full, m_cmd_ovr, m_rsp_ovr;
    logic [WIDTH-1:0] m_cmd_data, m_rsp_data;
    int               m_hold_left;   // edges remaining until sound reset released

    sw_mailbox_ctrl #(.WIDTH(WIDTH), .RST_CYCLES(RST_CYCLES)) dut (
        .Clk           (Clk),
        .Reset_bar     (Reset_bar),
        .main_wr       (main_wr),
        .main_din      (main_din),
        .main_rd       (main_rd),
        .main_dout     (main_dout),
        .snd_wr        (snd_wr),
        .snd_din       (snd_din),
        .snd_rd        (snd_rd),
        .snd_dout      (snd_dout),
        .cmd_full      (cmd_full),
        .rsp_full      (rsp_full),
        .cmd_ovr       (cmd_ovr),
        .rsp_ovr       (rsp_ovr),
        .snd_nmi       (snd_nmi),
        .snd_rst_req   (snd_rst_req),
        .snd_reset_bar (snd_reset_bar),
        .clr_ovr       (clr_ovr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cmd_full  = 1'b0;
        m_rsp_full  = 1'b0;
        m_cmd_ovr   = 1'b0;
        m_rsp_ovr   = 1'b0;
        m_cmd_data  = '0;
        m_rsp_data  = '0;
        m_hold_left = RST_CYCLES;
    endtask

    // One direction of the mailbox as described by its rules.
    task automatic chan_step(inout logic full, inout logic [WIDTH-1:0] data, inout logic ovr,
                             input logic wr, input logic [WIDTH-1:0] din, input logic rd,
                             input logic flush, input logic clr);
        logic overrun;
        overrun = wr && full && !rd;
        if (wr) data = din;
        if (flush) begin
            full = wr;
            ovr  = 1'b0;
        end else begin
            if (wr) full = 1'b1;
            else if (rd) full = 1'b0;
            if (overrun) ovr = 1'b1;
            else if (clr) ovr = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic holding, entering, snd_live;
        holding  = (m_hold_left > 0);
        entering = snd_rst_req && !holding;
        snd_live = !holding && !snd_rst_req;
        chan_step(m_cmd_full, m_cmd_data, m_cmd_ovr, main_wr, main_din,
                  snd_rd && snd_live, entering, clr_ovr);
        chan_step(m_rsp_full, m_rsp_data, m_rsp_ovr, snd_wr && snd_live, snd_din,
                  main_rd, entering, clr_ovr);
        if (snd_rst_req) m_hold_left = RST_CYCLES;
        else if (m_hold_left > 0) m_hold_left--;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".main_dout"}, main_dout, m_rsp_data);
        chk({tag, ".snd_dout"},  snd_dout,  m_cmd_data);
        chk({tag, ".cmd_full"},  cmd_full,  m_cmd_full);
        chk({tag, ".rsp_full"},  rsp_full,  m_rsp_full);
        chk({tag, ".cmd_ovr"},   cmd_ovr,   m_cmd_ovr);
        chk({tag, ".rsp_ovr"},   rsp_ovr,   m_rsp_ovr);
        chk({tag, ".snd_nmi"},   snd_nmi,   m_cmd_full);
        chk({tag, ".rst_bar"},   snd_reset_bar, (m_hold_left == 0));
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic cycle(input logic mw, input logic [WIDTH-1:0] md, input logic mr,
                         input logic sw, input logic [WIDTH-1:0] sd, input logic sr,
                         input logic rq, input logic co, input string tag);
        main_wr     = mw;
        main_din    = md;
        main_rd     = mr;
        snd_wr      = sw;
        snd_din     = sd;
        snd_rd      = sr;
        snd_rst_req = rq;
        clr_ovr     = co;
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, tag);
    endtask

    initial begin
        Reset_bar = 1'b0;
        main_wr = 0; main_rd = 0; snd_wr = 0; snd_rd = 0; snd_rst_req = 0; clr_ovr = 0;
        main_din = '0; snd_din = '0;
        model_reset();
        #12;
        Reset_bar = 1'b1;
        #1;
        check_all("reset");

        // sound CPU held for RST_CYCLES edges after release
        idle(RST_CYCLES - 1, "por_hold");
        chk("por_still_low", snd_reset_bar, 1'b0);
        idle(1, "por_release");
        chk("por_high", snd_reset_bar, 1'b1);

        // command write then consume
        cycle(1, 8'h5A, 0, 0, 8'h00, 0, 0, 0, "cmd_wr");
        chk("cmd_wr_dout", snd_dout, 8'h5A);
        chk("cmd_wr_nmi", snd_nmi, 1'b1);
        cycle(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, "cmd_rd");
        chk("cmd_rd_full", cmd_full, 1'b0);
        chk("cmd_rd_keep", snd_dout, 8'h5A);

        // command overrun and clear
        cycle(1, 8'h11, 0, 0, 8'h00, 0, 0, 0, "ovr_a");
        cycle(1, 8'h22, 0, 0, 8'h00, 0, 0, 0, "ovr_b");
        chk("ovr_dout", snd_dout, 8'h22);
        chk("ovr_flag", cmd_ovr, 1'b1);
        cycle(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, "ovr_clr");
        chk("ovr_cleared", cmd_ovr, 1'b0);

        // response write and read in the same cycle
        cycle(0, 8'h00, 0, 1, 8'h33, 0, 0, 0, "rsp_wr");
        cycle(0, 8'h00, 1, 1, 8'h44, 0, 0, 0, "rsp_wr_rd");
        chk("wr_rd_dout", main_dout, 8'h44);
        chk("wr_rd_full", rsp_full, 1'b1);
        chk("wr_rd_ovr", rsp_ovr, 1'b0);

        // reset request with both channels full
        cycle(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, "req1");
        chk("req_cmd_empty", cmd_full, 1'b0);
        chk("req_rsp_empty", rsp_full, 1'b0);
        chk("req_low", snd_reset_bar, 1'b0);
        idle(4, "hold_a");
        cycle(0, 8'h00, 0, 1, 8'h77, 0, 0, 0, "hold_sndwr");
        chk("hold_sndwr_ign", rsp_full, 1'b0);
        idle(4, "hold_b");
        cycle(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, "req2");
        idle(RST_CYCLES - 1, "hold_c");
        chk("rerq_still_low", snd_reset_bar, 1'b0);
        idle(1, "rerq_release");
        chk("rerq_high", snd_reset_bar, 1'b1);

        // async reset in the middle of a hold with a command queued
        cycle(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, "req3");
        cycle(1, 8'h99, 0, 0, 8'h00, 0, 0, 0, "hold_mainwr");
        chk("hold_mainwr_full", cmd_full, 1'b1);
        #2;
        Reset_bar = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_dout", snd_dout, 8'h00);
        @(negedge Clk);
        Reset_bar = 1'b1;
        idle(RST_CYCLES, "por2");
        chk("por2_high", snd_reset_bar, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 3) == 0, WIDTH'($urandom), ($urandom % 3) == 0,
                  ($urandom % 3) == 0, WIDTH'($urandom), ($urandom % 3) == 0,
                  ($urandom % 80) == 0, ($urandom % 16) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
